// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack
// and buffers {pc, instruction} pairs for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic        decode_ready,
  output logic        stat_fetch_busy
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_pend;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_mem_ins [BUF_DEPTH];
  logic [31:0]   r_mem_pc  [BUF_DEPTH];

  logic [31:0]   w_tgt;
  logic [31:0]   w_pc_inc;
  logic          w_ack;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_room;
  logic          w_unused;

  assign w_tgt     = {redirect_pc[31:2], 2'b00};
  assign w_unused  = ^redirect_pc[1:0];
  assign w_pc_inc  = r_pc + 32'd4;
  assign w_ack     = r_req & imem_ack;
  assign w_pop     = (r_count != '0) & decode_ready
                   & ~redirect_valid;
  assign w_push    = (r_state == REQ) & w_ack
                   & ~redirect_valid;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_room    = w_cnt_nxt < CW'(BUF_DEPTH);

  assign imem_req        = r_req;
  assign imem_addr       = r_addr;
  assign stat_fetch_busy = r_req;
  assign out_valid       = (r_count != '0);
  assign out_instruction = r_mem_ins[r_rptr];
  assign out_pc          = r_mem_pc[r_rptr];

  // Fetch FSM: issues requests, tracks PC, absorbs redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_pend  <= '0;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_pc <= w_tgt;
          end else if (ctrl_fetch_enable && w_room) begin
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            if (w_ack) begin
              r_pc    <= w_tgt;
              r_req   <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_pend  <= w_tgt;
              r_state <= DRAIN;
            end
          end else if (w_ack) begin
            r_pc <= w_pc_inc;
            if (ctrl_fetch_enable && w_room) begin
              r_addr <= w_pc_inc;
            end else begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (w_ack) begin
            r_pc    <= redirect_valid ? w_tgt : r_pend;
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else if (redirect_valid) begin
            r_pend <= w_tgt;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect_valid) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // FIFO storage: capture the acked word with its fetch PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem_ins[i] <= '0;
        r_mem_pc[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_ins[r_wptr] <= imem_rdata;
      r_mem_pc[r_wptr]  <= r_pc;
    end
  end

endmodule
